ethernet_rx: RTL and testbench

//  Receive-side counterpart of the ST2110 Ethernet encapsulation path: parses incoming Ethernet

---
 rtl/eth_pkg.sv | 20 ++
 rtl/sat_counter.sv | 28 ++
 rtl/ethernet_rx.sv | 153 +++++++++++++++
 tb/tb_ethernet_rx.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet receive path: EtherType and MAC
// constants, the header length in 32-bit words, and the receive FSM states.
// -----------------------------------------------------------------------------
package eth_pkg;

    typedef logic [47:0] mac_addr_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam mac_addr_t   MAC_BCAST      = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_HDR_WORDS  = 4;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_PAYLOAD,
        RX_DROP
    } eth_rx_state_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears the count
//   inc    in   count one event this cycle
//   count  out  current count, WIDTH bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request unless already at the top value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ethernet_rx.sv
// -----------------------------------------------------------------------------
// ethernet_rx
// Parses incoming Ethernet frames word by word, checks destination MAC and
// EtherType, strips the 4-word header and forwards the payload (RTP) words.
// Frames that fail the checks, or end inside the header, are dropped whole.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   eth_rx_data   frame word (header layout assumes 32-bit words)
//   eth_rx_valid  word valid; gaps allowed anywhere in a frame
//   eth_rx_last   final word of the frame (qualified by valid)
//   rtp_data      payload word, one cycle after it arrived
//   rtp_valid     payload word valid pulse
//   rtp_last      final payload word of an accepted frame
//   frame_ok      pulse when an accepted frame completes
//   frame_drop    pulse when a frame is discarded (at its last word)
//   frame_count   accepted frames, saturating
//   drop_count    dropped frames, saturating
// -----------------------------------------------------------------------------
module ethernet_rx
    import eth_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter mac_addr_t LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter bit        PROMISC    = 1'b0,
    parameter int        CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] eth_rx_data,
    input  logic                  eth_rx_valid,
    input  logic                  eth_rx_last,
    output logic [DATA_WIDTH-1:0] rtp_data,
    output logic                  rtp_valid,
    output logic                  rtp_last,
    output logic                  frame_ok,
    output logic                  frame_drop,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [1:0] HDR_LAST = 2'(ETH_HDR_WORDS - 1);

    eth_rx_state_t         state, state_nxt;
    logic [1:0]            hdr_cnt, hdr_cnt_nxt;
    logic [31:0]           dst_hi, dst_hi_nxt;
    logic                  dst_ok, dst_ok_nxt;
    mac_addr_t             dst_full;
    logic [DATA_WIDTH-1:0] rtp_data_nxt;
    logic                  rtp_valid_nxt, rtp_last_nxt;
    logic                  ok_nxt, drop_nxt;

    // State and registered outputs. Output pulses are computed combinationally
    // and registered here so every output appears one cycle after its input word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_HDR;
            hdr_cnt    <= 2'd0;
            dst_hi     <= '0;
            dst_ok     <= 1'b0;
            rtp_data   <= '0;
            rtp_valid  <= 1'b0;
            rtp_last   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            state      <= state_nxt;
            hdr_cnt    <= hdr_cnt_nxt;
            dst_hi     <= dst_hi_nxt;
            dst_ok     <= dst_ok_nxt;
            rtp_data   <= rtp_data_nxt;
            rtp_valid  <= rtp_valid_nxt;
            rtp_last   <= rtp_last_nxt;
            frame_ok   <= ok_nxt;
            frame_drop <= drop_nxt;
        end
    end

    // Next-state and output decode. Only valid cycles move anything forward.
    // The destination check is resolved on w1 (the upper half of dst was kept
    // from w0) so that w3 only has to look at the EtherType. A last flag on
    // any header word is a runt and is dropped immediately, even on w3.
    always_comb begin
        state_nxt     = state;
        hdr_cnt_nxt   = hdr_cnt;
        dst_hi_nxt    = dst_hi;
        dst_ok_nxt    = dst_ok;
        rtp_data_nxt  = rtp_data;
        rtp_valid_nxt = 1'b0;
        rtp_last_nxt  = 1'b0;
        ok_nxt        = 1'b0;
        drop_nxt      = 1'b0;
        dst_full      = {dst_hi, eth_rx_data[31:16]};

        if (eth_rx_valid) begin
            unique case (state)
                RX_HDR: begin
                    if (hdr_cnt == 2'd0) begin
                        dst_hi_nxt = eth_rx_data[31:0];
                    end
                    if (hdr_cnt == 2'd1) begin
                        dst_ok_nxt = PROMISC || (dst_full == LOCAL_MAC) ||
                                     (dst_full == MAC_BCAST);
                    end
                    if (eth_rx_last) begin
                        drop_nxt    = 1'b1;
                        hdr_cnt_nxt = 2'd0;
                    end else if (hdr_cnt == HDR_LAST) begin
                        hdr_cnt_nxt = 2'd0;
                        state_nxt   = ((eth_rx_data[31:16] == ETHERTYPE_IPV4) && dst_ok)
                                      ? RX_PAYLOAD : RX_DROP;
                    end else begin
                        hdr_cnt_nxt = hdr_cnt + 2'd1;
                    end
                end
                RX_PAYLOAD: begin
                    rtp_data_nxt  = eth_rx_data;
                    rtp_valid_nxt = 1'b1;
                    if (eth_rx_last) begin
                        rtp_last_nxt = 1'b1;
                        ok_nxt       = 1'b1;
                        state_nxt    = RX_HDR;
                    end
                end
                RX_DROP: begin
                    if (eth_rx_last) begin
                        drop_nxt  = 1'b1;
                        state_nxt = RX_HDR;
                    end
                end
                default: begin
                    state_nxt   = RX_HDR;
                    hdr_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

    // Counters bump on the same edge that raises the matching pulse.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_nxt),
        .count (frame_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_nxt),
        .count (drop_count)
    );

endmodule

// File: tb/tb_ethernet_rx.sv
// -----------------------------------------------------------------------------
// tb_ethernet_rx
// Bench for ethernet_rx. A frame-level model classifies each transmitted
// frame (runt / accepted / dropped) and predicts the payload stream and
// counters; a monitor collects what the design actually emits.
// A second instance with 2-bit counters shares the stimulus.
// -----------------------------------------------------------------------------
module tb_ethernet_rx;

    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_99;
    localparam logic [47:0] SRC    = 48'h0A_0B_0C_0D_0E_0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] eth_rx_data = '0;
    logic        eth_rx_valid = 1'b0;
    logic        eth_rx_last = 1'b0;

    logic [31:0] rtp_data, rtp_data_s;
    logic        rtp_valid, rtp_last, frame_ok, frame_drop;
    logic        rtp_valid_s, rtp_last_s, frame_ok_s, frame_drop_s;
    logic [15:0] frame_count, drop_count;
    logic [1:0]  frame_count_s, drop_count_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] tx_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    logic [32:0] saved_q[$];
    int exp_ok, exp_drop, exp_frames, exp_drops;
    int ok_seen, drop_seen, align_err, diverge;
    int first_rtp_cyc, w4_cyc;

    ethernet_rx dut (
        .clk(clk), .rst(rst),
        .eth_rx_data(eth_rx_data), .eth_rx_valid(eth_rx_valid), .eth_rx_last(eth_rx_last),
        .rtp_data(rtp_data), .rtp_valid(rtp_valid), .rtp_last(rtp_last),
        .frame_ok(frame_ok), .frame_drop(frame_drop),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    ethernet_rx #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .eth_rx_data(eth_rx_data), .eth_rx_valid(eth_rx_valid), .eth_rx_last(eth_rx_last),
        .rtp_data(rtp_data_s), .rtp_valid(rtp_valid_s), .rtp_last(rtp_last_s),
        .frame_ok(frame_ok_s), .frame_drop(frame_drop_s),
        .frame_count(frame_count_s), .drop_count(drop_count_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect payload words and pulses away from the active edge.
    always @(negedge clk) begin
        if (rtp_valid) begin
            got_q.push_back({rtp_last, rtp_data});
            if (first_rtp_cyc < 0) first_rtp_cyc = cyc;
        end
        if (frame_ok) ok_seen++;
        if (frame_drop) drop_seen++;
        if (frame_ok !== (rtp_valid && rtp_last)) align_err++;
        if (!rst && ({rtp_valid_s, rtp_last_s, frame_ok_s, frame_drop_s} !==
                     {rtp_valid, rtp_last, frame_ok, frame_drop} ||
                     (rtp_valid && rtp_data_s !== rtp_data)))
            diverge++;
    end

    // Build a frame: header for dst/etype followed by npay payload words.
    task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype,
                               input int npay, input logic rnd, input logic [31:0] base);
        tx_q.delete();
        tx_q.push_back(dst[47:16]);
        tx_q.push_back({dst[15:0], SRC[47:32]});
        tx_q.push_back(SRC[31:0]);
        tx_q.push_back({etype, 16'h0000});
        for (int i = 0; i < npay; i++)
            tx_q.push_back(rnd ? $urandom : base + 32'(i));
    endtask

    // Frame-level reference: whatever was placed in tx_q is one frame.
    task automatic predict();
        logic [47:0] dst;
        logic [15:0] et;
        int n;
        exp_q.delete();
        exp_ok = 0;
        exp_drop = 0;
        n = tx_q.size();
        if (n <= 4) begin
            exp_drop = 1;
        end else begin
            dst = {tx_q[0], tx_q[1][31:16]};
            et  = tx_q[3][31:16];
            if (et == 16'h0800 && (dst == MY_MAC || dst == BCAST)) begin
                for (int i = 4; i < n; i++) exp_q.push_back({(i == n - 1), tx_q[i]});
                exp_ok = 1;
            end else begin
                exp_drop = 1;
            end
        end
        exp_frames += exp_ok;
        exp_drops  += exp_drop;
    endtask

    // Drive the frame in tx_q with up to gap_max idle cycles before each word.
    task automatic applyStimulus(input int gap_max);
        predict();
        got_q.delete();
        ok_seen = 0;
        drop_seen = 0;
        first_rtp_cyc = -1;
        w4_cyc = -1;
        for (int i = 0; i < tx_q.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                eth_rx_valid = 1'b0;
                eth_rx_data  = $urandom;
                eth_rx_last  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            eth_rx_valid = 1'b1;
            eth_rx_data  = tx_q[i];
            eth_rx_last  = (i == tx_q.size() - 1);
            if (i == 4) w4_cyc = cyc;
            @(posedge clk); #1;
        end
        eth_rx_valid = 1'b0;
        eth_rx_last  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({rtp_valid, rtp_last, frame_ok, frame_drop, frame_count, drop_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v%b l%b ok%b dr%b fc%0d dc%0d, required all 0",
                     rtp_valid, rtp_last, frame_ok, frame_drop, frame_count, drop_count);
        end
        checks++;
        if ({frame_count_s, drop_count_s} !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_sat_counts: got %0d/%0d, required 0/0", frame_count_s, drop_count_s);
        end
    endtask

    task automatic test_accept();
        build_frame(MY_MAC, 16'h0800, 4, 1'b0, 32'h0000_00A0);
        applyStimulus(0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL accept_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL accept_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (ok_seen != 1 || frame_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL accept_ok: got pulses %0d count %0d, required 1/1", ok_seen, frame_count);
        end
        checks++;
        if (first_rtp_cyc != w4_cyc + 1) begin
            errors++;
            $display("[TB] FAIL accept_latency: first rtp at cycle %0d, required %0d", first_rtp_cyc, w4_cyc + 1);
        end
    endtask

    task automatic test_bad_ethertype();
        build_frame(MY_MAC, 16'h86DD, 4, 1'b0, 32'h0000_00A0);
        applyStimulus(0);
        checks++;
        if (got_q.size() != 0 || ok_seen != 0) begin
            errors++;
            $display("[TB] FAIL ethertype_nodata: got %0d words %0d ok, required 0/0", got_q.size(), ok_seen);
        end
        checks++;
        if (drop_seen != 1 || drop_count !== 16'(exp_drops)) begin
            errors++;
            $display("[TB] FAIL ethertype_drop: got pulses %0d count %0d, required 1/%0d",
                     drop_seen, drop_count, exp_drops);
        end
    endtask

    task automatic test_dst_filter();
        logic [47:0] dsts[2];
        dsts[0] = BCAST;
        dsts[1] = OTHER;
        for (int f = 0; f < 2; f++) begin
            build_frame(dsts[f], 16'h0800, 3, 1'b1, 32'h0);
            applyStimulus(0);
            checks++;
            if (got_q.size() != exp_q.size() || ok_seen != exp_ok || drop_seen != exp_drop) begin
                errors++;
                $display("[TB] FAIL dst%0d: got %0d words ok%0d drop%0d, required %0d words ok%0d drop%0d",
                         f, got_q.size(), ok_seen, drop_seen, exp_q.size(), exp_ok, exp_drop);
            end
            foreach (exp_q[i]) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL dst%0d_word%0d: got %h, required %h", f, i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (frame_count !== 16'(exp_frames) || drop_count !== 16'(exp_drops)) begin
            errors++;
            $display("[TB] FAIL dst_counts: got %0d/%0d, required %0d/%0d",
                     frame_count, drop_count, exp_frames, exp_drops);
        end
    endtask

    task automatic test_runt();
        build_frame(MY_MAC, 16'h0800, 4, 1'b1, 32'h0);
        while (tx_q.size() > 3) void'(tx_q.pop_back());
        applyStimulus(0);
        checks++;
        if (drop_seen != 1 || got_q.size() != 0 || drop_count !== 16'(exp_drops)) begin
            errors++;
            $display("[TB] FAIL runt_drop: got pulses %0d words %0d count %0d, required 1/0/%0d",
                     drop_seen, got_q.size(), drop_count, exp_drops);
        end
        build_frame(MY_MAC, 16'h0800, 2, 1'b1, 32'h0);
        applyStimulus(0);
        checks++;
        if (ok_seen != 1 || got_q.size() != 2 || got_q[1] !== exp_q[1]) begin
            errors++;
            $display("[TB] FAIL runt_recover: got ok %0d words %0d, required 1/2", ok_seen, got_q.size());
        end
    endtask

    task automatic test_gaps();
        build_frame(MY_MAC, 16'h0800, 5, 1'b1, 32'h0);
        applyStimulus(0);
        saved_q = got_q;
        applyStimulus(3);
        checks++;
        if (got_q.size() != saved_q.size() || ok_seen != 1) begin
            errors++;
            $display("[TB] FAIL gaps_len: got %0d words ok %0d, required %0d/1", got_q.size(), ok_seen, saved_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_q[i] !== saved_q[i]) begin
                errors++;
                $display("[TB] FAIL gaps_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [47:0] dst;
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 2))
                0: dst = MY_MAC;
                1: dst = BCAST;
                default: dst = {$urandom, 16'($urandom)};
            endcase
            build_frame(dst, ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h86DD,
                        $urandom_range(0, 6), 1'b1, 32'h0);
            if ($urandom_range(0, 5) == 0)
                while (tx_q.size() > $urandom_range(1, 4)) void'(tx_q.pop_back());
            applyStimulus(2);
            checks++;
            if (got_q.size() != exp_q.size() || ok_seen != exp_ok || drop_seen != exp_drop) begin
                errors++;
                $display("[TB] FAIL rand%0d: got %0d words ok%0d drop%0d, required %0d words ok%0d drop%0d",
                         f, got_q.size(), ok_seen, drop_seen, exp_q.size(), exp_ok, exp_drop);
            end
            foreach (exp_q[i]) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_word%0d: got %h, required %h", f, i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (frame_count !== 16'(exp_frames) || drop_count !== 16'(exp_drops)) begin
            errors++;
            $display("[TB] FAIL rand_counts: got %0d/%0d, required %0d/%0d",
                     frame_count, drop_count, exp_frames, exp_drops);
        end
        checks++;
        if (align_err != 0 || diverge != 0) begin
            errors++;
            $display("[TB] FAIL pulse_align: got %0d misaligned %0d divergent cycles, required 0/0", align_err, diverge);
        end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(MY_MAC, 16'h0800, 4, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            eth_rx_valid = 1'b1;
            eth_rx_data  = tx_q[i];
            eth_rx_last  = 1'b0;
            @(posedge clk); #1;
        end
        eth_rx_data = tx_q[5];
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rtp_valid, rtp_last, frame_ok, frame_drop, frame_count, drop_count} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_async: got v%b l%b ok%b dr%b fc%0d dc%0d, required all 0",
                     rtp_valid, rtp_last, frame_ok, frame_drop, frame_count, drop_count);
        end
        eth_rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_frames = 0;
        exp_drops = 0;
        build_frame(MY_MAC, 16'h0800, 3, 1'b1, 32'h0);
        applyStimulus(1);
        checks++;
        if (ok_seen != 1 || frame_count !== 16'd1 || got_q.size() != 3 || got_q[2] !== exp_q[2]) begin
            errors++;
            $display("[TB] FAIL rst_recover: got ok %0d count %0d words %0d, required 1/1/3",
                     ok_seen, frame_count, got_q.size());
        end
        for (int f = 0; f < 5; f++) begin
            build_frame(OTHER, 16'h0800, 2, 1'b1, 32'h0);
            applyStimulus(1);
        end
        checks++;
        if (drop_count !== 16'(exp_drops) || drop_count_s !== 2'((exp_drops > 3) ? 3 : exp_drops)) begin
            errors++;
            $display("[TB] FAIL saturate: got %0d/%0d, required %0d/%0d",
                     drop_count, drop_count_s, exp_drops, (exp_drops > 3) ? 3 : exp_drops);
        end
        checks++;
        if (frame_count_s !== 2'd1) begin
            errors++;
            $display("[TB] FAIL sat_frames: got %0d, required 1", frame_count_s);
        end
    endtask

    initial begin
        exp_frames = 0;
        exp_drops = 0;
        align_err = 0;
        diverge = 0;
        first_rtp_cyc = -1;
        #23 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_accept();
        test_bad_ethertype();
        test_dst_filter();
        test_runt();
        test_gaps();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
